commit_trace_buffer: RTL and testbench



---
 rtl/commit_trace_buffer_pkg.sv | 48 ++++
 rtl/commit_trace_buffer_if.sv | 41 ++++
 rtl/commit_trace_buffer_fifo.sv | 49 ++++
 rtl/commit_trace_buffer.sv | 115 +++++++++++
 tb/tb_commit_trace_buffer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_buffer_pkg.sv
// Shared types and record layout for the commit trace buffer.
// Entry width grows by one word when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } trace_state_e;

    localparam int OPC_W = 6;
    localparam int REG_W = 5;

    // Record layout, LSB first: wr_data, wr_addr, opcode, pc, [timestamp]
    function automatic int wd_lsb(int ws);
        return 0;
    endfunction

    function automatic int ra_lsb(int ws);
        return ws;
    endfunction

    function automatic int op_lsb(int ws);
        return ws + REG_W;
    endfunction

    function automatic int pc_lsb(int ws);
        return ws + REG_W + OPC_W;
    endfunction

    function automatic int base_w(int ws);
        return 2 * ws + REG_W + OPC_W;
    endfunction

    function automatic int ts_lsb(int ws);
        return base_w(ws);
    endfunction

    function automatic int entry_w(int ws);
`ifdef TRACE_TIMESTAMP_EN
        return base_w(ws) + ws;
`else
        return base_w(ws);
`endif
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Valid/ready drain stream carrying one trace record per beat.
// out_timestamp exists only when TRACE_TIMESTAMP_EN is defined.
interface commit_trace_buffer_if
    import trace_pkg::*;
#(
    parameter int WORD_SIZE = 32
);
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_pc;
    logic [OPC_W-1:0]     out_opcode;
    logic [REG_W-1:0]     out_wr_addr;
    logic [WORD_SIZE-1:0] out_wr_data;
`ifdef TRACE_TIMESTAMP_EN
    logic [WORD_SIZE-1:0] out_timestamp;
`endif

    modport master (
        output out_valid,
        output out_pc,
        output out_opcode,
        output out_wr_addr,
        output out_wr_data,
`ifdef TRACE_TIMESTAMP_EN
        output out_timestamp,
`endif
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_opcode,
        input  out_wr_addr,
        input  out_wr_data,
`ifdef TRACE_TIMESTAMP_EN
        input  out_timestamp,
`endif
        output out_ready
    );
endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign level   = cnt;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
            else if (pop_ok && !push_ok) cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/commit_trace_buffer.sv
// Trigger-armed commit trace capture into a FWFT FIFO with stream drain.
// Define TRACE_TIMESTAMP_EN to tag each record with a free-running cycle count.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 16,
    parameter int LEN_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_valid,
    input  logic [WORD_SIZE-1:0]   prog_count,
    input  logic [OPC_W-1:0]       instr_opcode,
    input  logic [REG_W-1:0]       write_reg_addr,
    input  logic [WORD_SIZE-1:0]   write_reg_data,
    input  logic                   arm,
    input  logic                   disarm,
    input  logic [WORD_SIZE-1:0]   trig_pc,
    input  logic [LEN_W-1:0]       trig_len,
    commit_trace_buffer_if.master  out_bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [LEN_W-1:0]       drop_cnt
);
    localparam int EW = entry_w(WORD_SIZE);

    trace_state_e     state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic             hit, pop, drop, full, empty;
    logic [EW-1:0]    din, dout;

`ifdef TRACE_TIMESTAMP_EN
    logic [WORD_SIZE-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 1'b1;
    end

    assign din = {ts_q, prog_count, instr_opcode,
                  write_reg_addr, write_reg_data};
    assign out_bus.out_timestamp = dout[ts_lsb(WORD_SIZE) +: WORD_SIZE];
`else
    assign din = {prog_count, instr_opcode,
                  write_reg_addr, write_reg_data};
`endif

    assign out_bus.out_pc      = dout[pc_lsb(WORD_SIZE) +: WORD_SIZE];
    assign out_bus.out_opcode  = dout[op_lsb(WORD_SIZE) +: OPC_W];
    assign out_bus.out_wr_addr = dout[ra_lsb(WORD_SIZE) +: REG_W];
    assign out_bus.out_wr_data = dout[wd_lsb(WORD_SIZE) +: WORD_SIZE];
    assign out_bus.out_valid   = !empty;

    // Control pulses own their cycle: no sample qualifies alongside arm/disarm
    assign hit = cap_valid && !arm && !disarm &&
                 ((state == ST_ARMED && prog_count == trig_pc) ||
                  state == ST_CAPTURE);
    assign pop     = out_bus.out_valid && out_bus.out_ready;
    assign drop    = hit && full && !pop;
    assign cnt_inc = cnt_q + 1'b1;

    trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hit),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_nxt = state;
        if (disarm)   state_nxt = ST_IDLE;
        else if (arm) state_nxt = ST_ARMED;
        else if (hit) begin
            if (len_q != '0 && cnt_inc == len_q) state_nxt = ST_DONE;
            else                                 state_nxt = ST_CAPTURE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (arm && !disarm) begin
                len_q    <= trig_len;
                cnt_q    <= '0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (hit) begin
                cnt_q <= cnt_inc;
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign done = (state == ST_DONE);
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_commit_trace_buffer;
    localparam int WS = 32;
    localparam int DP = 16;
    localparam int LW = 16;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  ra;
        logic [31:0] wd;
        logic [31:0] ts;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_valid = 1'b0;
    logic [31:0] prog_count = '0;
    logic [5:0]  instr_opcode = '0;
    logic [4:0]  write_reg_addr = '0;
    logic [31:0] write_reg_data = '0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [15:0] trig_len = '0;
    logic [4:0]  level;
    logic        busy, done, overflow;
    logic [15:0] drop_cnt;

    commit_trace_buffer_if #(.WORD_SIZE(WS)) ob ();

    commit_trace_buffer #(.WORD_SIZE(WS), .DEPTH(DP), .LEN_W(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cap_valid      (cap_valid),
        .prog_count     (prog_count),
        .instr_opcode   (instr_opcode),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .arm            (arm),
        .disarm         (disarm),
        .trig_pc        (trig_pc),
        .trig_len       (trig_len),
        .out_bus        (ob),
        .level          (level),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: 0 idle, 1 armed, 2 capture, 3 done
    rec_t        q[$];
    rec_t        drained[$];
    int          m_st = 0;
    int          m_len = 0;
    int          m_cnt = 0;
    int          m_drop = 0;
    bit          m_ovf = 0;
    logic [31:0] m_ts = '0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int   n;
        bit   pop, hit;
        rec_t r;
        if (rst) begin
            q.delete();
            m_st = 0; m_len = 0; m_cnt = 0;
            m_drop = 0; m_ovf = 0; m_ts = '0;
            return;
        end
        n   = q.size();
        pop = (n > 0) && ob.out_ready;
        hit = cap_valid && !arm && !disarm &&
              ((m_st == 1 && prog_count == trig_pc) || m_st == 2);
        r.pc = prog_count; r.op = instr_opcode; r.ra = write_reg_addr;
        r.wd = write_reg_data; r.ts = m_ts;
        if (pop) begin
            drained.push_back(q[0]);
            void'(q.pop_front());
        end
        if (hit) begin
            if (n < DP || pop) q.push_back(r);
            else begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
            m_cnt++;
            m_st = (m_len != 0 && m_cnt == m_len) ? 3 : 2;
        end
        if (disarm) m_st = 0;
        else if (arm) begin
            m_st = 1; m_len = int'(trig_len); m_cnt = 0;
            m_ovf = 0; m_drop = 0;
        end
        m_ts = m_ts + 1;
    endtask

    task automatic compare_all();
        rec_t h;
        bit   v;
        v = q.size() > 0;
        h = '{default: '0};
        if (v) h = q[0];
        chk("out_valid", 64'(ob.out_valid), 64'(v));
        chk("level", 64'(level), 64'(q.size()));
        chk("busy", 64'(busy), 64'(m_st == 1 || m_st == 2));
        chk("done", 64'(done), 64'(m_st == 3));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("out_pc", 64'(ob.out_pc), 64'(h.pc));
        chk("out_opcode", 64'(ob.out_opcode), 64'(h.op));
        chk("out_wr_addr", 64'(ob.out_wr_addr), 64'(h.ra));
        chk("out_wr_data", 64'(ob.out_wr_data), 64'(h.wd));
`ifdef TRACE_TIMESTAMP_EN
        chk("out_timestamp", 64'(ob.out_timestamp), 64'(h.ts));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic sample(logic v, logic [31:0] pc);
        cap_valid      = v;
        prog_count     = pc;
        instr_opcode   = 6'($urandom);
        write_reg_addr = 5'($urandom);
        write_reg_data = $urandom;
    endtask

    task automatic pulse_arm(logic [31:0] tpc, logic [15:0] tlen);
        trig_pc = tpc; trig_len = tlen;
        sample(1'b0, '0);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    initial begin
        ob.out_ready = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        chk("reset level", 64'(level), 64'd0);
        chk("reset valid", 64'(ob.out_valid), 64'd0);
        rst = 1'b0;

`ifdef TRACE_TIMESTAMP_EN
        ob.out_ready = 1'b1;
        trig_pc = 32'd28; trig_len = 16'd3;
        for (int k = 0; k < 13; k++) begin
            arm = (k == 0);
            sample(1'b1, 32'(4 * k));
            cyc();
        end
        arm = 1'b0;
        chk("ts count", 64'(drained.size()), 64'd3);
        for (int i = 0; i < 3 && i < drained.size(); i++)
            chk("ts value", 64'(drained[i].ts), 64'(7 + i));
        drained.delete();
`endif

        // Trigger window of three records
        ob.out_ready = 1'b1;
        pulse_arm(32'h10, 16'd3);
        for (int k = 0; k <= 8; k++) begin
            sample(1'b1, 32'(4 * k));
            cyc();
        end
        sample(1'b0, '0);
        cyc();
        cyc();
        chk("t1 count", 64'(drained.size()), 64'd3);
        for (int i = 0; i < 3 && i < drained.size(); i++)
            chk("t1 pc", 64'(drained[i].pc), 64'(32'h10 + 4 * i));
        chk("t1 done", 64'(done), 64'd1);
        chk("t1 busy", 64'(busy), 64'd0);
        drained.delete();

        // Overflow with a stalled sink
        ob.out_ready = 1'b0;
        pulse_arm(32'h100, 16'd20);
        for (int k = 0; k < 24; k++) begin
            sample(1'b1, 32'(32'h100 + 4 * k));
            cyc();
        end
        chk("t2 level", 64'(level), 64'd16);
        chk("t2 overflow", 64'(overflow), 64'd1);
        chk("t2 drop_cnt", 64'(drop_cnt), 64'd4);
        chk("t2 done", 64'(done), 64'd1);
        ob.out_ready = 1'b1;
        sample(1'b0, '0);
        for (int k = 0; k < 18; k++) cyc();
        chk("t2 count", 64'(drained.size()), 64'd16);
        for (int i = 0; i < 16 && i < drained.size(); i++)
            chk("t2 pc", 64'(drained[i].pc), 64'(32'h100 + 4 * i));
        drained.delete();

        // Full FIFO with simultaneous push and pop
        ob.out_ready = 1'b0;
        pulse_arm(32'h200, 16'd0);
        for (int k = 0; k < 16; k++) begin
            sample(1'b1, 32'(32'h200 + 4 * k));
            cyc();
        end
        chk("t3 filled", 64'(level), 64'd16);
        ob.out_ready = 1'b1;
        for (int k = 16; k < 26; k++) begin
            sample(1'b1, 32'(32'h200 + 4 * k));
            cyc();
            chk("t3 level", 64'(level), 64'd16);
            chk("t3 overflow", 64'(overflow), 64'd0);
        end

        // arm and disarm together while capturing
        ob.out_ready = 1'b0;
        sample(1'b1, 32'h300);
        arm = 1'b1; disarm = 1'b1;
        cyc();
        arm = 1'b0; disarm = 1'b0;
        chk("t4 busy", 64'(busy), 64'd0);
        chk("t4 done", 64'(done), 64'd0);
        chk("t4 valid", 64'(ob.out_valid), 64'd1);
        drained.delete();
        ob.out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            sample(1'b1, 32'(32'h400 + 4 * k));
            cyc();
        end
        chk("t4 drained", 64'(drained.size()), 64'd16);
        chk("t4 level", 64'(level), 64'd0);
        drained.delete();

        // Reset mid-capture
        ob.out_ready = 1'b0;
        pulse_arm(32'h500, 16'd0);
        for (int k = 0; k < 5; k++) begin
            sample(1'b1, 32'(32'h500 + 4 * k));
            cyc();
        end
        chk("t5 level", 64'(level), 64'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5 valid", 64'(ob.out_valid), 64'd0);
        chk("t5 level0", 64'(level), 64'd0);
        chk("t5 drop", 64'(drop_cnt), 64'd0);
        chk("t5 busy", 64'(busy), 64'd0);

        // Randomized traffic over a small PC space so triggers recur
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 299) == 0);
            arm          = ($urandom_range(0, 19) == 0);
            disarm       = ($urandom_range(0, 49) == 0);
            ob.out_ready = ($urandom_range(0, 2) != 0);
            if (arm) begin
                trig_pc  = 32'(4 * $urandom_range(0, 7));
                trig_len = 16'($urandom_range(0, 24));
            end
            sample($urandom_range(0, 4) != 0, 32'(4 * $urandom_range(0, 7)));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
